// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - state encoding and lamp decode for the traffic controller
package traffic_pkg;

   localparam int STATE_W = 3;

   localparam logic [STATE_W-1:0] S_G1    = 3'd0;
   localparam logic [STATE_W-1:0] S_Y1    = 3'd1;
   localparam logic [STATE_W-1:0] S_AR1   = 3'd2;
   localparam logic [STATE_W-1:0] S_G2    = 3'd3;
   localparam logic [STATE_W-1:0] S_Y2    = 3'd4;
   localparam logic [STATE_W-1:0] S_AR2   = 3'd5;
   localparam logic [STATE_W-1:0] S_FLASH = 3'd6;

   // Lamp vectors, bit order {r1, y1, g1, r2, y2, g2}.
   localparam logic [5:0] LAMP_G1 = 6'b001_100;
   localparam logic [5:0] LAMP_Y1 = 6'b010_100;
   localparam logic [5:0] LAMP_AR = 6'b100_100;
   localparam logic [5:0] LAMP_G2 = 6'b100_001;
   localparam logic [5:0] LAMP_Y2 = 6'b100_010;

   // Decode lamps from the state register and flash phase only; an
   // unknown code shows all-red so the intersection stays safe.
   function automatic logic [5:0] lamps_of(input logic [STATE_W-1:0] st,
                                           input logic phase);
      logic [5:0] v;
      case (st)
         S_G1:        v = LAMP_G1;
         S_Y1:        v = LAMP_Y1;
         S_AR1, S_AR2: v = LAMP_AR;
         S_G2:        v = LAMP_G2;
         S_Y2:        v = LAMP_Y2;
         S_FLASH:     v = {1'b0, phase, 1'b0, 1'b0, phase, 1'b0};
         default:     v = LAMP_AR;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - prescaler producing a one-cycle tick every TICK_DIV clocks
module tick_gen #(
   parameter int TICK_DIV = 50000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);

   localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [W-1:0] cnt;

   assign tick = (cnt == W'(TICK_DIV - 1));

   // Count 0..TICK_DIV-1; a state change restarts the count so each state
   // gets whole ticks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/traffic_ctrl.sv
// rtl/traffic_ctrl.sv - two-direction traffic light controller with pedestrian and night modes
module traffic_ctrl
   import traffic_pkg::*;
#(
   parameter int TICK_DIV = 50000000,
   parameter int G1_SEC   = 30,
   parameter int G2_SEC   = 25,
   parameter int Y_SEC    = 5,
   parameter int AR_SEC   = 1,
   parameter int PED_MIN  = 5,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             night,
   input  logic             ped_req,
   output logic             r1,
   output logic             y1,
   output logic             g1,
   output logic             r2,
   output logic             y2,
   output logic             g2,
   output logic [CNT_W-1:0] remain,
   output logic [2:0]       state
);

   localparam logic [CNT_W-1:0] T_G1  = CNT_W'(G1_SEC - 1);
   localparam logic [CNT_W-1:0] T_G2  = CNT_W'(G2_SEC - 1);
   localparam logic [CNT_W-1:0] T_Y   = CNT_W'(Y_SEC - 1);
   localparam logic [CNT_W-1:0] T_AR  = CNT_W'(AR_SEC - 1);
   localparam logic [CNT_W-1:0] T_PED = CNT_W'(PED_MIN - 1);

   logic [STATE_W-1:0] state_q, state_d, seq_next;
   logic [CNT_W-1:0]   timer_q, timer_d;
   logic               flash_q, flash_d;
   logic               tick, clr;
   logic               is_green;

   // Timer load value on entry; FLASH keeps the timer parked at zero.
   function automatic logic [CNT_W-1:0] entry_timer(input logic [STATE_W-1:0] st);
      logic [CNT_W-1:0] t;
      case (st)
         S_G1:         t = T_G1;
         S_G2:         t = T_G2;
         S_Y1, S_Y2:   t = T_Y;
         S_AR1, S_AR2: t = T_AR;
         default:      t = '0;
      endcase
      return t;
   endfunction

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .tick  (tick)
   );

   // State register, seconds timer and flash phase.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_G1;
         timer_q <= T_G1;
         flash_q <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         flash_q <= flash_d;
      end
   end

   // Next state: expiry first, then pedestrian truncation, then decrement.
   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      flash_d  = flash_q;
      clr      = 1'b0;
      is_green = (state_q == S_G1) || (state_q == S_G2);

      // Night mode is only honoured at the end of an all-red clearance.
      case (state_q)
         S_G1:    seq_next = S_Y1;
         S_Y1:    seq_next = S_AR1;
         S_AR1:   seq_next = night ? S_FLASH : S_G2;
         S_G2:    seq_next = S_Y2;
         S_Y2:    seq_next = S_AR2;
         S_AR2:   seq_next = night ? S_FLASH : S_G1;
         default: seq_next = S_AR2;
      endcase

      if (state_q == S_FLASH) begin
         timer_d = '0;
         if (tick) begin
            if (!night) begin
               state_d = S_AR2;
               timer_d = T_AR;
               flash_d = 1'b0;
               clr     = 1'b1;
            end else begin
               flash_d = ~flash_q;
            end
         end
      end else if (state_q > S_FLASH) begin
         // Unreachable codes recover through an all-red clearance.
         state_d = S_AR2;
         timer_d = T_AR;
         flash_d = 1'b0;
         clr     = 1'b1;
      end else if (tick && (timer_q == '0)) begin
         state_d = seq_next;
         timer_d = entry_timer(seq_next);
         flash_d = 1'b0;
         clr     = 1'b1;
      end else if (is_green && ped_req && (timer_q > T_PED)) begin
         timer_d = T_PED;
      end else if (tick) begin
         timer_d = timer_q - CNT_W'(1);
      end
   end

   // Moore outputs decoded from registered state only.
   always_comb begin
      {r1, y1, g1, r2, y2, g2} = lamps_of(state_q, flash_q);
      remain = timer_q;
      state  = state_q;
   end

endmodule
